// File: rtl/sdes_pkg.sv
// Shared definitions for the S-DES sequential engine: FSM states and the
// fixed bit permutations. Bit 1 of the classic tables is the MSB of each word.
package sdes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    ROUND1 = 3'd2,
    ROUND2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  // P10: 3 5 2 7 4 10 1 9 8 6
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // Circular left shift by one of each 5-bit half
  function automatic logic [9:0] ls1(input logic [9:0] k);
    return {k[8:5], k[9], k[3:0], k[4]};
  endfunction

  // P8: 6 3 7 4 8 5 10 9 (bits 1 and 2 are dropped)
  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  // IP: 2 6 3 1 4 8 5 7
  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction

  // IP^-1: 4 1 3 5 7 2 8 6
  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction

  // EP: 4 1 2 3 2 3 4 1 on a 4-bit half
  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  // P4: 2 4 3 1
  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // S-box lookup: row = {b1,b4}, col = {b2,b3}, entry idx = row*4+col
  function automatic logic [1:0] sbox(input logic [31:0] tab, input logic [3:0] n);
    logic [3:0] idx;
    idx = {n[3], n[0], n[2], n[1]};
    return tab[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// Combinational S-DES round function fk: left nibble XOR F(right, subkey),
// right nibble passes through unchanged.
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [7:0]  subkey,
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  output logic [7:0]  result
);

  logic [7:0] mixed;
  logic [3:0] f_out;

  assign mixed  = ep(data[3:0]) ^ subkey;
  assign f_out  = p4({sbox(s0, mixed[7:4]), sbox(s1, mixed[3:0])});
  assign result = {data[7:4] ^ f_out, data[3:0]};

endmodule

// File: rtl/sdes_seq_engine.sv
// Multi-cycle S-DES encrypt/decrypt engine with a one-entry subkey cache.
// One fk instance is shared by both rounds; the key schedule runs in KEYGEN.
module sdes_seq_engine
  import sdes_pkg::*;
#(
  parameter int KEY_CACHE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [7:0]  data_in,
  input  logic [9:0]  key,
  input  logic [31:0] S0,
  input  logic [31:0] S1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  data_out,
  output logic        busy
);

  state_t      state_reg;
  logic        mode_reg;
  logic [7:0]  data_reg;
  logic [9:0]  key_reg;
  logic [31:0] s0_reg;
  logic [31:0] s1_reg;
  logic [7:0]  work_reg;
  logic [7:0]  k1_reg;
  logic [7:0]  k2_reg;
  logic [9:0]  cache_key_reg;
  logic        cache_valid_reg;
  logic        in_ready_reg;
  logic        busy_reg;
  logic        out_valid_reg;
  logic [7:0]  data_out_reg;

  logic [9:0]  ls1_key;
  logic [9:0]  ls3_key;
  logic [7:0]  k1_next;
  logic [7:0]  k2_next;
  logic        cache_hit;
  logic        use_k1;
  logic [7:0]  fk_data;
  logic [7:0]  fk_key;
  logic [7:0]  fk_result;

  // Key schedule works from the latched key so late input changes cannot leak in
  assign ls1_key = ls1(p10(key_reg));
  assign ls3_key = ls1(ls1(ls1_key));
  assign k1_next = p8(ls1_key);
  assign k2_next = p8(ls3_key);

  // Hit compares the live key against the cached one; subkeys depend only on key
  assign cache_hit = (KEY_CACHE != 0) && cache_valid_reg && (key == cache_key_reg);

  // Round 1 takes K1 when encrypting, round 2 takes K1 when decrypting
  assign use_k1  = (state_reg == ROUND1) ? ~mode_reg : mode_reg;
  assign fk_key  = use_k1 ? k1_reg : k2_reg;
  assign fk_data = (state_reg == ROUND1) ? ip(data_reg) : work_reg;

  sdes_fk u_fk (
    .data   (fk_data),
    .subkey (fk_key),
    .s0     (s0_reg),
    .s1     (s1_reg),
    .result (fk_result)
  );

  // Sequencer: latches a request, runs keygen/rounds and holds the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      mode_reg        <= 1'b0;
      data_reg        <= 8'h00;
      key_reg         <= 10'h000;
      s0_reg          <= 32'h0;
      s1_reg          <= 32'h0;
      work_reg        <= 8'h00;
      k1_reg          <= 8'h00;
      k2_reg          <= 8'h00;
      cache_key_reg   <= 10'h000;
      cache_valid_reg <= 1'b0;
      in_ready_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      out_valid_reg   <= 1'b0;
      data_out_reg    <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mode_reg     <= mode;
            data_reg     <= data_in;
            key_reg      <= key;
            s0_reg       <= S0;
            s1_reg       <= S1;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= cache_hit ? ROUND1 : KEYGEN;
          end
        end
        KEYGEN: begin
          k1_reg          <= k1_next;
          k2_reg          <= k2_next;
          cache_key_reg   <= key_reg;
          cache_valid_reg <= 1'b1;
          state_reg       <= ROUND1;
        end
        ROUND1: begin
          work_reg  <= {fk_result[3:0], fk_result[7:4]};
          state_reg <= ROUND2;
        end
        ROUND2: begin
          data_out_reg  <= ip_inv(fk_result);
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign data_out  = data_out_reg;

endmodule

// File: tb/tb_sdes_seq_engine.sv
// Scoreboard bench for sdes_seq_engine: the driver queues hand-computed
// results with their expected latency, a monitor checks each new output.
module tb_sdes_seq_engine;

  localparam logic [31:0] SB0  = 32'hB7D81BB1;
  localparam logic [31:0] SB1  = 32'hC613D2E4;
  localparam logic [9:0]  KEYA = 10'b1010000010;
  localparam logic [9:0]  KEYZ = 10'b0000000000;

  typedef struct {
    logic [7:0] data;
    int         lat;
    int         acc;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [9:0]  key = 10'h000;
  logic [31:0] s0 = SB0;
  logic [31:0] s1 = SB1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  data_out;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  sdes_seq_engine #(.KEY_CACHE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .data_in   (data_in),
    .key       (key),
    .S0        (s0),
    .S1        (s1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Present a request until accepted and queue its expected result
  task automatic send(input logic m, input logic [7:0] d, input logic [9:0] k,
                      input logic [7:0] res, input int lat, input string name);
    exp_t e;
    int   n;
    @(negedge clk);
    mode = m; data_in = d; key = k; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_accept"}, {31'd0, in_ready}, 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    e.data = res; e.lat = lat; e.acc = cyc + 1; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, {31'd0, (sb.size() == 0 && in_ready)}, 32'd1);
  endtask

  // Monitor: each fresh out_valid pops one expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_data"}, {24'd0, data_out}, {24'd0, e.data});
          chk({e.name, "_latency"}, cyc - e.acc, e.lat);
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Encrypt (miss) followed immediately by decrypt (hit)
    send(1'b0, 8'b10010111, KEYA, 8'b00111000, 3, "enc_a");
    send(1'b1, 8'b00111000, KEYA, 8'b10010111, 2, "dec_a");
    drain("enc_dec");

    // Backpressure in DONE
    out_ready = 1'b0;
    send(1'b0, 8'b10010111, KEYA, 8'b00111000, 2, "bp_enc");
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, data_out}, 32'h38);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Reset during ROUND1 (cache hit => ROUND1 right after accept)
    @(negedge clk);
    mode = 1'b0; data_in = 8'b10010111; key = KEYA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rel_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) @(negedge clk);
    send(1'b0, 8'b10010111, KEYA, 8'b00111000, 3, "post_rst_enc");
    drain("post_rst");

    // Key change: new key forces KEYGEN, then a hit on the same key
    send(1'b0, 8'h00, KEYZ, 8'hF0, 3, "enc_z");
    send(1'b1, 8'hF0, KEYZ, 8'h00, 2, "dec_z");
    drain("key_change");

    // Inputs toggled every cycle while busy must not disturb the result
    @(negedge clk);
    mode = 1'b0; data_in = 8'b10010111; key = KEYA; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    begin
      exp_t e;
      e.data = 8'b00111000; e.lat = 3; e.acc = cyc + 1; e.name = "perturb_enc";
      sb.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) begin
        data_in = ~data_in;
        key     = ~key;
        mode    = ~mode;
        s0      = ~s0;
      end
    end while (!out_valid && n < 20);
    in_valid = 1'b0;
    s0 = SB0;
    drain("perturb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdes_seq_engine.md
SDES_SEQ_ENGINE -- requirements
Module: sdes_seq_engine

Interface
REQ-001 SHALL have parameter KEY_CACHE, default 1, which enables reuse of the previously expanded subkeys when the key is unchanged.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  engine can accept a request.
REQ-006 mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 data_in  input  8  plaintext or ciphertext.
REQ-008 key  input  10  S-DES key.
REQ-009 S0, S1  input  32 each  S-box tables; entry idx = row*4+col occupies bits [2*idx+1:2*idx].
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 data_out  output  8  ciphertext or decrypted text.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL use the FSM states IDLE, KEYGEN, ROUND1, ROUND2 and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept occurs when in_valid and in_ready are both 1, latching mode, data_in, key, S0 and S1.
REQ-016 On accept, the FSM SHALL go IDLE->KEYGEN, except when KEY_CACHE=1, the cache is valid and key equals the cached key, where it SHALL go IDLE->ROUND1.
REQ-017 KEYGEN SHALL compute K1 = P8(LS1(P10(key))) and K2 = P8(LS2(LS1(P10(key)))), register both, set the cache key and cache-valid, then go to ROUND1.
REQ-018 ROUND1 SHALL register SW(fk(IP(data), Ka)) with Ka = K1 when encrypting and K2 when decrypting, then go to ROUND2.
REQ-019 ROUND2 SHALL register IP^-1(fk(state, Kb)) with Kb = K2 when encrypting and K1 when decrypting, then go to DONE.
REQ-020 fk SHALL be defined as follows: the left nibble is XORed with F(right nibble, subkey) and the right nibble passes through unchanged.
REQ-021 F SHALL compute P4(S0[row,col] || S1[row,col]) of EP(R) XOR subkey, with row = {b1,b4} and col = {b2,b3} using MSB-first numbering of each 4-bit half.
REQ-022 DONE SHALL hold out_valid = 1 with data_out stable until out_ready = 1, then go to IDLE; in_ready SHALL rise the following cycle.
REQ-023 Latency from the accept edge to out_valid SHALL be 3 cycles on a cache miss and 2 cycles on a cache hit.
REQ-024 Changes to inputs during a busy state SHALL NOT affect the result in flight.
REQ-025 The cache compare SHALL use key only; mode and S-boxes SHALL NOT invalidate the cache, because subkeys depend only on key.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 in_valid SHALL be ignored outside IDLE.

Reset
REQ-028 rst_n low SHALL force, asynchronously, state = IDLE, out_valid = 0, data_out = 8'h00, busy = 0, cache-valid = 0 and subkeys = 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no output.
REQ-030 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-031 The package sdes_pkg SHALL hold the FSM state enum and the P10, P8, IP, IP^-1, EP and P4 permutation constants or functions.
REQ-032 The combinational round function SHALL be the sub-module sdes_fk, with inputs 8-bit data, 8-bit subkey, S0 and S1 and an 8-bit output, instantiated once and time-shared across ROUND1 and ROUND2 via a subkey mux.
REQ-033 The key schedule SHALL be inline logic in sdes_seq_engine.

Verification
REQ-034 Encrypt test: S0 = 32'hB7D81BB1, S1 = 32'hC613D2E4, key = 10'b1010000010, data_in = 8'b10010111, mode = 0 -> data_out = 8'b00111000 with out_valid exactly 3 cycles after accept.
REQ-035 Decrypt test with the same key and S-boxes: data_in = 8'b00111000, mode = 1, issued immediately after REQ-034 with KEY_CACHE = 1 -> data_out = 8'b10010111 with 2-cycle latency (cache hit).
REQ-036 Backpressure test: out_ready held 0 for 5 cycles in DONE -> out_valid and data_out stable for all 5 cycles, in_ready = 0; one cycle after out_ready = 1, in_ready = 1.
REQ-037 Reset in ROUND1: rst_n pulsed low -> out_valid = 0 and in_ready = 1 after release; the next request with the same key takes 3 cycles (cache cleared).
REQ-038 Key change test: with the cache valid, a request with a new key -> KEYGEN is visited (3-cycle latency) and the result matches the reference model.
REQ-039 Input perturbation test: data_in, key and mode toggled every cycle while busy -> the result equals the one computed from the values latched at accept.
